// File: rtl/hpdcache_mem_read_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hpdcache_mem_read_sched                                          |
// | Brief   : round-robin read-request scheduler with per-requester            |
// |           outstanding-burst limits and ID-based response routing.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hpdcache_mem_read_sched #(
  parameter  int N_REQ   = 4,
  parameter  int ID_W    = 4,
  parameter  int REQ_W   = 128,
  parameter  int RESP_W  = 512,
  parameter  int MAX_OUT = 8,
  localparam int IDX_W   = $clog2(N_REQ),
  localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*ID_W-1:0]   req_id_i,
  input  logic [N_REQ*REQ_W-1:0]  req_data_i,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [IDX_W+ID_W-1:0]   mem_req_id_o,
  output logic [REQ_W-1:0]        mem_req_data_o,
  input  logic                    mem_resp_valid_i,
  output logic                    mem_resp_ready_o,
  input  logic [IDX_W+ID_W-1:0]   mem_resp_id_i,
  input  logic                    mem_resp_last_i,
  input  logic [RESP_W-1:0]       mem_resp_data_i,
  output logic [N_REQ-1:0]        resp_valid_o,
  input  logic [N_REQ-1:0]        resp_ready_i,
  output logic [ID_W-1:0]         resp_id_o,
  output logic                    resp_last_o,
  output logic [RESP_W-1:0]       resp_data_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam logic [0:0]       c_st_arb   = 1'b0;
  localparam logic [0:0]       c_st_issue = 1'b1;
  localparam logic [CNT_W-1:0] c_max_out  = CNT_W'(MAX_OUT);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_grant;
  logic [CNT_W-1:0] r_cnt [N_REQ];
  logic             r_err;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_nonzero;
  logic [N_REQ-1:0] w_inc;
  logic [N_REQ-1:0] w_dec;
  logic [N_REQ-1:0] w_zero_last;
  logic             w_found;
  logic [IDX_W-1:0] w_sel;
  int               w_cand;
  logic [IDX_W-1:0] w_resp_idx;
  logic             w_resp_in_range;
  logic             w_resp_fire;
  logic             w_issue_fire;
  logic             w_err;

  assign w_resp_idx      = mem_resp_id_i[IDX_W+ID_W-1:ID_W];
  assign w_resp_in_range = int'(w_resp_idx) < N_REQ;
  assign w_resp_fire     = mem_resp_valid_i && mem_resp_ready_o;
  assign w_issue_fire    = (r_state == c_st_issue) && mem_req_ready_i;

  // Search starts one past the last accepted requester so every index gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = (int'(r_ptr) + k) % N_REQ;
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(w_cand);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (r_state == c_st_issue) req_ready_o[r_grant] = mem_req_ready_i;
  end

  assign mem_req_valid_o = (r_state == c_st_issue);
  assign mem_req_id_o    = {r_grant, req_id_i[r_grant*ID_W +: ID_W]};
  assign mem_req_data_o  = req_data_i[r_grant*REQ_W +: REQ_W];

  // Out-of-range IDs are sunk so a bad response can never stall the channel.
  always_comb begin
    resp_valid_o     = '0;
    mem_resp_ready_o = 1'b1;
    if (w_resp_in_range) begin
      resp_valid_o[w_resp_idx] = mem_resp_valid_i;
      mem_resp_ready_o         = resp_ready_i[w_resp_idx];
    end
  end

  assign resp_id_o   = mem_resp_id_i[ID_W-1:0];
  assign resp_last_o = mem_resp_last_i;
  assign resp_data_o = mem_resp_data_i;

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
      assign w_elig[i]      = req_valid_i[i] && (r_cnt[i] < c_max_out);
      assign w_nonzero[i]   = (r_cnt[i] != '0);
      assign w_inc[i]       = w_issue_fire && (r_grant == IDX_W'(i));
      assign w_zero_last[i] = w_resp_fire && mem_resp_last_i && w_resp_in_range
                              && (w_resp_idx == IDX_W'(i)) && !w_nonzero[i];
      assign w_dec[i]       = w_resp_fire && mem_resp_last_i && w_resp_in_range
                              && (w_resp_idx == IDX_W'(i)) && w_nonzero[i];

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_cnt[i] <= '0;
        end else if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec[i] && !w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  endgenerate

  assign w_err  = w_resp_fire && (!w_resp_in_range || (|w_zero_last));
  assign busy_o = |w_nonzero;
  assign err_o  = r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= c_st_arb;
      r_ptr   <= IDX_W'(N_REQ - 1);
      r_grant <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      case (r_state)
        c_st_arb: begin
          if (w_found) begin
            r_grant <= w_sel;
            r_state <= c_st_issue;
          end
        end
        default: begin
          if (mem_req_ready_i) begin
            r_ptr   <= r_grant;
            r_state <= c_st_arb;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_mem_read_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_hpdcache_mem_read_sched                                       |
// | Brief   : directed self-checking bench for the read-request scheduler.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_hpdcache_mem_read_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_id;
  logic [63:0] req_data;
  logic        mem_req_valid, mem_req_ready;
  logic [5:0]  mem_req_id;
  logic [15:0] mem_req_data;
  logic        mem_resp_valid, mem_resp_ready, mem_resp_last;
  logic [5:0]  mem_resp_id;
  logic [7:0]  mem_resp_data;
  logic [3:0]  resp_valid, resp_ready;
  logic [3:0]  resp_id;
  logic        resp_last;
  logic [7:0]  resp_data;
  logic        busy, err;

  // Second instance with a non-power-of-two requester count to reach out-of-range IDs.
  logic [2:0]  b_req_ready, b_resp_valid_o, b_resp_ready;
  logic        b_mem_req_valid, b_mem_resp_valid, b_mem_resp_ready, b_mem_resp_last;
  logic [5:0]  b_mem_req_id, b_mem_resp_id;
  logic [15:0] b_mem_req_data;
  logic [3:0]  b_resp_id;
  logic        b_resp_last, b_busy, b_err;
  logic [7:0]  b_resp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hpdcache_mem_read_sched #(
    .N_REQ(4), .ID_W(4), .REQ_W(16), .RESP_W(8), .MAX_OUT(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_id_i(req_id), .req_data_i(req_data),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_id_o(mem_req_id), .mem_req_data_o(mem_req_data),
    .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready),
    .mem_resp_id_i(mem_resp_id), .mem_resp_last_i(mem_resp_last), .mem_resp_data_i(mem_resp_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
    .resp_last_o(resp_last), .resp_data_o(resp_data), .busy_o(busy), .err_o(err)
  );

  hpdcache_mem_read_sched #(
    .N_REQ(3), .ID_W(4), .REQ_W(16), .RESP_W(8), .MAX_OUT(2)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(3'b000), .req_ready_o(b_req_ready), .req_id_i(12'h0), .req_data_i(48'h0),
    .mem_req_valid_o(b_mem_req_valid), .mem_req_ready_i(1'b1),
    .mem_req_id_o(b_mem_req_id), .mem_req_data_o(b_mem_req_data),
    .mem_resp_valid_i(b_mem_resp_valid), .mem_resp_ready_o(b_mem_resp_ready),
    .mem_resp_id_i(b_mem_resp_id), .mem_resp_last_i(b_mem_resp_last), .mem_resp_data_i(8'h00),
    .resp_valid_o(b_resp_valid_o), .resp_ready_i(b_resp_ready), .resp_id_o(b_resp_id),
    .resp_last_o(b_resp_last), .resp_data_o(b_resp_data), .busy_o(b_busy), .err_o(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single response beat with every requester ready.
  task automatic beat(input int idx, input bit last);
    mem_resp_valid = 1'b1;
    mem_resp_id    = {idx[1:0], 4'h5};
    mem_resp_last  = last;
    mem_resp_data  = 8'h5A;
    resp_ready     = 4'hF;
    #1;
    chk("beat_vld",  resp_valid, 4'b0001 << idx);
    chk("beat_id",   resp_id, 4'h5);
    chk("beat_data", resp_data, 8'h5A);
    chk("beat_rdy",  mem_resp_ready, 1'b1);
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_last  = 1'b0;
    resp_ready     = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'h0; mem_req_ready = 1'b0;
    req_id   = {4'h4, 4'h3, 4'h2, 4'h1};
    req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    mem_resp_valid = 1'b0; mem_resp_id = '0; mem_resp_last = 1'b0; mem_resp_data = '0;
    resp_ready = 4'h0;
    b_mem_resp_valid = 1'b0; b_mem_resp_id = '0; b_mem_resp_last = 1'b0; b_resp_ready = 3'b000;
    tick(); tick();
    chk("rst_mreq_valid", mem_req_valid, 1'b0);
    chk("rst_req_ready",  req_ready, 4'h0);
    chk("rst_busy",       busy, 1'b0);
    chk("rst_err",        err, 1'b0);
    rst_n = 1'b1;

    // Round robin across all four requesters, one request every two cycles.
    req_valid = 4'hF; mem_req_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_valid", mem_req_valid, 1'b1);
      chk("rr_id",    mem_req_id, ((g % 4) << 4) | ((g % 4) + 1));
      chk("rr_data",  mem_req_data, 16'hA000 + (g % 4));
      chk("rr_ready", req_ready, 4'b0001 << (g % 4));
      tick();
      chk("rr_gap",   mem_req_valid, 1'b0);
    end
    req_valid = 4'h0;
    chk("rr_busy", busy, 1'b1);
    beat(0, 1'b1); beat(0, 1'b1); beat(1, 1'b1); beat(2, 1'b1); beat(3, 1'b1);
    chk("drain_busy", busy, 1'b0);
    chk("drain_err",  err, 1'b0);

    // Stall on requester 2 for five cycles.
    req_valid = 4'b0100; mem_req_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", mem_req_valid, 1'b1);
      chk("stall_id",    mem_req_id, 6'h23);
      chk("stall_data",  mem_req_data, 16'hA002);
      chk("stall_ready", req_ready, 4'h0);
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("stall_accept", req_ready, 4'b0100);
    tick();
    req_valid = 4'h0;
    chk("stall_done", mem_req_valid, 1'b0);

    // Accept and last beat for requester 2 in the same cycle: counter stays at 1.
    req_valid = 4'b0100;
    tick();
    chk("conc_id", mem_req_id, 6'h23);
    mem_resp_valid = 1'b1; mem_resp_id = 6'h20; mem_resp_last = 1'b1; resp_ready = 4'b0100;
    #1;
    chk("conc_ready", req_ready, 4'b0100);
    tick();
    mem_resp_valid = 1'b0; mem_resp_last = 1'b0; resp_ready = 4'h0; req_valid = 4'h0;
    chk("conc_err",  err, 1'b0);
    chk("conc_busy", busy, 1'b1);
    beat(2, 1'b1);
    chk("conc_clear_busy", busy, 1'b0);
    chk("conc_clear_err",  err, 1'b0);

    // Saturate requester 1 at MAX_OUT.
    req_valid = 4'b0010;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("sat_grant", mem_req_id[5:4], 2'd1);
      tick();
    end
    req_valid = 4'b1010;
    tick();
    chk("sat_other_valid", mem_req_valid, 1'b1);
    chk("sat_other_grant", mem_req_id[5:4], 2'd3);
    tick();
    req_valid = 4'b0010;
    tick();
    chk("sat_skip0", mem_req_valid, 1'b0);
    tick();
    chk("sat_skip1", mem_req_valid, 1'b0);
    beat(1, 1'b1);
    chk("sat_wait", mem_req_valid, 1'b0);
    tick();
    chk("sat_regrant_valid", mem_req_valid, 1'b1);
    chk("sat_regrant_id",    mem_req_id[5:4], 2'd1);
    tick();
    req_valid = 4'h0;
    for (int n = 0; n < 8; n++) beat(1, 1'b1);
    chk("sat_drain_busy", busy, 1'b1);

    // Four-beat burst to requester 3 with its ready toggling.
    for (int b = 0; b < 4; b++) begin
      mem_resp_valid = 1'b1; mem_resp_id = 6'h37; mem_resp_last = (b == 3); resp_ready = 4'h0;
      #1;
      chk("burst_vld",     resp_valid, 4'b1000);
      chk("burst_hold",    mem_resp_ready, 1'b0);
      tick();
      resp_ready = 4'b1000;
      #1;
      chk("burst_rdy",     mem_resp_ready, 1'b1);
      chk("burst_last",    resp_last, (b == 3));
      tick();
      mem_resp_valid = 1'b0; mem_resp_last = 1'b0; resp_ready = 4'h0;
      chk("burst_busy",    busy, (b == 3) ? 1'b0 : 1'b1);
    end
    chk("burst_err", err, 1'b0);

    // Last beat to an idle counter.
    beat(0, 1'b1);
    chk("zero_err_hi", err, 1'b1);
    tick();
    chk("zero_err_lo", err, 1'b0);
    chk("zero_busy",   busy, 1'b0);

    // Out-of-range response index.
    b_mem_resp_valid = 1'b1; b_mem_resp_id = 6'h31; b_resp_ready = 3'b000;
    #1;
    chk("oor_ready", b_mem_resp_ready, 1'b1);
    chk("oor_vld",   b_resp_valid_o, 3'b000);
    tick();
    b_mem_resp_valid = 1'b0;
    chk("oor_err_hi", b_err, 1'b1);
    tick();
    chk("oor_err_lo", b_err, 1'b0);
    chk("oor_busy",   b_busy, 1'b0);

    // Reset while a grant is pending.
    req_valid = 4'b0001; mem_req_ready = 1'b1;
    tick(); tick();
    mem_req_ready = 1'b0;
    tick();
    chk("mid_valid", mem_req_valid, 1'b1);
    chk("mid_busy",  busy, 1'b1);
    rst_n = 1'b0; req_valid = 4'h0;
    tick();
    chk("mid_rst_valid", mem_req_valid, 1'b0);
    chk("mid_rst_ready", req_ready, 4'h0);
    chk("mid_rst_busy",  busy, 1'b0);
    chk("mid_rst_err",   err, 1'b0);
    rst_n = 1'b1;
    beat(0, 1'b1);
    chk("post_rst_err", err, 1'b1);
    req_valid = 4'hF; mem_req_ready = 1'b1;
    tick();
    chk("post_rst_grant", mem_req_id[5:4], 2'd0);
    tick();
    req_valid = 4'h0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
